// File: rtl/word_packer.sv
// word_packer: AXI-Stream width gearbox that packs narrow words into wide
// phrases. A frame end produces a partial phrase with a keep mask. A new
// frame that arrives before the phrase is full flushes the partial phrase
// first. A decoupled output register sustains one word per cycle.
module word_packer #(
  parameter int WORD_W = 16,
  parameter int WORDS  = 8,
  parameter int ORDER  = 0
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [WORD_W-1:0]         data_in,
  input  logic                      newframe_in,
  input  logic                      last_in,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [WORD_W*WORDS-1:0]   data_out,
  output logic [WORDS-1:0]          keep_out,
  output logic                      tuser_out,
  output logic                      tlast_out,
  output logic                      frame_err_out
);

  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  logic [CW-1:0]           count;
  logic                    acc_tuser;
  logic [WORD_W-1:0]       slots [WORDS];

  logic                    slot_free;
  logic                    complete;
  logic                    nf_pending;
  logic                    flush_now;
  logic                    accept;
  logic                    load;
  logic [WORD_W-1:0]       lane_word;
  logic [WORD_W*WORDS-1:0] next_data;
  logic [WORDS-1:0]        next_keep;

  // Handshake decode: a truncating newframe word is held off until the partial phrase is flushed
  always_comb begin
    slot_free  = ~valid_out | ready_out;
    complete   = (count == LAST_IDX) | last_in;
    nf_pending = valid_in & newframe_in & (count != '0);
    flush_now  = nf_pending & slot_free;
    ready_in   = ~nf_pending & (slot_free | ((count != LAST_IDX) & ~last_in));
    accept     = valid_in & ready_in;
    load       = flush_now | (accept & complete);
  end

  // Phrase builder: stored slots, the incoming word at slot[count] unless flushing, zeros above
  always_comb begin
    next_data = '0;
    next_keep = '0;
    lane_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (CW'(i) < count) begin
        lane_word    = slots[i];
        next_keep[i] = 1'b1;
      end else if ((CW'(i) == count) && !flush_now) begin
        lane_word    = data_in;
        next_keep[i] = 1'b1;
      end else begin
        lane_word    = '0;
      end
      if (ORDER == 0) begin
        next_data[i*WORD_W +: WORD_W] = lane_word;
      end else begin
        next_data[(WORDS-1-i)*WORD_W +: WORD_W] = lane_word;
      end
    end
  end

  // Slot storage: unfilled slots are masked by the builder, so no reset is needed
  always_ff @(posedge clk_in) begin
    if (accept && !complete) begin
      slots[count] <= data_in;
    end
  end

  // Accumulator fill level and frame-start flag of the phrase being built
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count     <= '0;
      acc_tuser <= 1'b0;
    end else if (flush_now) begin
      count     <= '0;
    end else if (accept) begin
      if (complete) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
        if (count == '0) begin
          acc_tuser <= newframe_in;
        end
      end
    end
  end

  // Output register: loads a completed or flushed phrase, otherwise drains on ready_out
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out     <= 1'b0;
      data_out      <= '0;
      keep_out      <= '0;
      tuser_out     <= 1'b0;
      tlast_out     <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      frame_err_out <= flush_now;
      if (load) begin
        valid_out <= 1'b1;
        data_out  <= next_data;
        keep_out  <= next_keep;
        if (flush_now) begin
          tuser_out <= acc_tuser;
          tlast_out <= 1'b1;
        end else begin
          tuser_out <= (count == '0) ? newframe_in : acc_tuser;
          tlast_out <= last_in;
        end
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule
